c_addsub_pipe: RTL and testbench
================================

# c_addsub_pipe

Parametrised, multi-lane, pipelined signed adder/subtractor with valid/ready flow control and per-lane overflow detection; the next generation of the FDTD ALU add/sub primitive. Each accepted transaction carries LANES independent operand pairs and a per-lane add/subtract select. Results emerge a fixed STAGES cycles later, and backpressure stalls the whole pipeline. It sits between the FDTD field-update sequencer and the multiplier/accumulator stages in the user-plugin ALU.

## Interface
- WIDTH, 32: operand/result width per lane, signed two's complement, ≥2.
- LANES, 4: independent lanes per transaction, ≥1.
- STAGES, 2: pipeline depth (accept-to-output latency), ≥1.

- CLK  in  1  clock, all state on rising edge.
- RSTN  in  1  asynchronous active-low reset; deassertion synchronous to CLK is the integrator's responsibility.
- IN_VALID  in  1  operand set present.
- IN_READY  out  1  block accepts operand set this cycle.
- ADD  in  LANES  per lane: 1 = A+B, 0 = A−B.
- A  in  LANES*WIDTH  signed operands, lane i at [i*WIDTH +: WIDTH].
- B  in  LANES*WIDTH  signed operands, same packing.
- OUT_VALID  out  1  result set present.
- OUT_READY  in  1  downstream accepts result.
- S  out  LANES*WIDTH  signed results, same packing.
- OVF  out  LANES  per lane: true result outside WIDTH-bit signed range.

## Operation
- Pipeline: STAGES register slots, each holding a valid bit, LANES results and LANES OVF bits. The last slot drives OUT_VALID, S and OVF directly.
- Advance condition: adv = !OUT_VALID || OUT_READY. IN_READY = adv, combinational with no dependence on IN_VALID.
- When adv = 1, all slots shift one step. Slot 0 loads IN_VALID plus the computed results. A bubble is loaded when IN_VALID = 0.
- When adv = 0, all slots hold, including bubbles. There is no bubble collapsing.
- Acceptance requires IN_VALID && IN_READY. Output transfer requires OUT_VALID && OUT_READY.
- Arithmetic, done at slot-0 load:
  - Sign-extend A and B to WIDTH+1 bits.
  - r = A+B if ADD[i], else A−B.
  - OVF[i] = r[WIDTH] ≠ r[WIDTH−1].
- Stages 1..STAGES−1 are pure delay registers.
- S and OVF hold their values while OUT_VALID = 1 and OUT_READY = 0. While OUT_VALID = 0, they hold the last-shifted contents, which are don't-care to consumers.
- Reset (RSTN low, asynchronous, at any time including mid-stream):
  - All valid bits, S and OVF clear to 0.
  - In-flight transactions are discarded.
  - IN_READY reads 1 while in reset.
- Simultaneous accept and output transfer in the same cycle is legal. Sustained throughput is one transaction per cycle when OUT_READY is held high.

## Timing
- Latency: a transaction accepted at edge k appears with OUT_VALID = 1 after edge k+STAGES−1, when there is no stall. For STAGES = 1, the result is visible the cycle after acceptance.
- Each stall cycle adds exactly one cycle of latency to every in-flight transaction.
- Output values after reset: OUT_VALID = 0, S = 0, OVF = 0, IN_READY = 1.
- IN_READY has a combinational path from OUT_READY. No other combinational input-to-output paths exist.

## Configuration
- C_ADDSUB_SAT_EN defined:
  - Each lane whose OVF is set has S clamped to 2^(WIDTH−1)−1 if r is positive, and to −2^(WIDTH−1) if r is negative.
  - The sign of r is r[WIDTH].
  - The clamp is applied at the slot-0 load, so latency is unchanged.
- C_ADDSUB_SAT_EN undefined:
  - S = r[WIDTH−1:0], i.e. wrap-around.
  - OVF is still reported.

## Test plan
All scenarios use WIDTH=8, LANES=2, STAGES=2 unless noted.
- Reset: hold RSTN=0 mid-stream with 2 transactions in flight, then release. Required: OUT_VALID=0, S=0, OVF=0, IN_READY=1, and no stale result ever appears.
- Basic streaming: send back-to-back transactions with OUT_READY=1.
  - Lane 0 ADD=1, A=5, B=3 → S=8.
  - Lane 1 ADD=0, A=−4, B=10 → S=−14.
  - Both OVF=0, OUT_VALID=1 two cycles after acceptance, one result per cycle.
- Overflow: lane 0 ADD=1, A=100, B=50; lane 1 ADD=0, A=−100, B=60.
  - Both OVF=1.
  - With C_ADDSUB_SAT_EN: S = 127 and −128.
  - Without: S = −106 and 96.
- Backpressure: stream 5 transactions while holding OUT_READY=0 for 4 cycles, with the first result present.
  - IN_READY=0 throughout the stall.
  - S holds steady.
  - After release, all 5 results arrive in order with none lost or duplicated.
- Bubbles: pulse IN_VALID in the pattern 1,0,1 with OUT_READY=1. Required: OUT_VALID follows 1,0,1, delayed by 2 cycles.
- Parametric: STAGES=1, LANES=1, WIDTH=16, A=−32768, B=1, ADD=0. Required: OVF=1 one cycle after acceptance; S=32767 without the macro, S=−32768 with it.

Source files
------------

// File: rtl/c_addsub_pipe.sv
// Multi-lane pipelined signed add/sub with valid/ready flow control and per-lane overflow.
// Optional saturation on overflow is enabled by defining C_ADDSUB_SAT_EN.
module c_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES-1:0]       ADD,
    input  logic [LANES*WIDTH-1:0] A,
    input  logic [LANES*WIDTH-1:0] B,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES*WIDTH-1:0] S,
    output logic [LANES-1:0]       OVF
);

    logic                                 adv;
    logic [LANES*WIDTH-1:0]               s_d;
    logic [LANES-1:0]                     ovf_d;
    logic [STAGES-1:0]                    vld_q;
    logic [STAGES-1:0][LANES*WIDTH-1:0]   s_q;
    logic [STAGES-1:0][LANES-1:0]         ovf_q;

    // Whole pipeline moves as one; bubbles are held, never collapsed.
    assign adv      = !vld_q[STAGES-1] || OUT_READY;
    assign IN_READY = adv;

    always_comb begin : arith
        logic [WIDTH:0] a_ext;
        logic [WIDTH:0] b_ext;
        logic [WIDTH:0] r;
        s_d   = '0;
        ovf_d = '0;
        a_ext = '0;
        b_ext = '0;
        r     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a_ext = {A[i*WIDTH+WIDTH-1], A[i*WIDTH +: WIDTH]};
            b_ext = {B[i*WIDTH+WIDTH-1], B[i*WIDTH +: WIDTH]};
            r     = ADD[i] ? (a_ext + b_ext) : (a_ext - b_ext);
            ovf_d[i] = r[WIDTH] ^ r[WIDTH-1];
`ifdef C_ADDSUB_SAT_EN
            if (ovf_d[i]) begin
                s_d[i*WIDTH +: WIDTH] = r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                s_d[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
            end
`else
            s_d[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q <= '0;
            s_q   <= '0;
            ovf_q <= '0;
        end else if (adv) begin
            vld_q[0] <= IN_VALID;
            s_q[0]   <= s_d;
            ovf_q[0] <= ovf_d;
            for (int unsigned k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                s_q[k]   <= s_q[k-1];
                ovf_q[k] <= ovf_q[k-1];
            end
        end
    end

    assign OUT_VALID = vld_q[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign OVF       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_c_addsub_pipe.sv
// Scoreboard bench for c_addsub_pipe: 8-bit/2-lane/2-stage main instance and a
// 16-bit/1-lane/1-stage parametric instance. Honors C_ADDSUB_SAT_EN.
module tb_c_addsub_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    always #5 clk = ~clk;

    logic        iv, ir, ov, ordy;
    logic [1:0]  add;
    logic [15:0] a, b, s;
    logic [1:0]  ovf;

    logic        piv, pir, pov, pordy;
    logic [0:0]  padd;
    logic [15:0] pa, pb, ps;
    logic [0:0]  povf;

    int total = 0;
    int bad   = 0;
    int rx    = 0;

    typedef struct { logic [15:0] s; logic [1:0] ovf; } exp_t;
    typedef struct { logic [15:0] s; logic ovf; } pexp_t;
    exp_t  qa[$];
    pexp_t qp[$];

    c_addsub_pipe #(.WIDTH(8), .LANES(2), .STAGES(2)) u_dut (
        .CLK(clk), .RSTN(rstn), .IN_VALID(iv), .IN_READY(ir), .ADD(add),
        .A(a), .B(b), .OUT_VALID(ov), .OUT_READY(ordy), .S(s), .OVF(ovf)
    );

    c_addsub_pipe #(.WIDTH(16), .LANES(1), .STAGES(1)) u_par (
        .CLK(clk), .RSTN(rstn), .IN_VALID(piv), .IN_READY(pir), .ADD(padd),
        .A(pa), .B(pb), .OUT_VALID(pov), .OUT_READY(pordy), .S(ps), .OVF(povf)
    );

    // Reference: integer arithmetic with explicit range test, then clamp or wrap.
    function automatic logic [16:0] model(input int w, input int x, input int y, input bit ad);
        int   r, mx, mn;
        logic o;
        r  = ad ? x + y : x - y;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        o  = (r > mx) || (r < mn);
`ifdef C_ADDSUB_SAT_EN
        if (o) r = (r > 0) ? mx : mn;
`endif
        return {o, r[15:0]};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e, g;
        pexp_t       pe;
        logic [16:0] m0, m1;
        if (rstn) begin
            if (ov && ordy) begin
                total++;
                rx++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL mon_unexpected got s=%h ovf=%b required none", s, ovf);
                end else begin
                    e = qa.pop_front();
                    if (s !== e.s || ovf !== e.ovf) begin
                        bad++;
                        $display("FAIL mon_result got s=%h ovf=%b required s=%h ovf=%b", s, ovf, e.s, e.ovf);
                    end
                end
            end
            if (iv && ir) begin
                m0 = model(8, int'($signed(a[7:0])), int'($signed(b[7:0])), add[0]);
                m1 = model(8, int'($signed(a[15:8])), int'($signed(b[15:8])), add[1]);
                g.s   = {m1[7:0], m0[7:0]};
                g.ovf = {m1[16], m0[16]};
                qa.push_back(g);
            end
            if (pov && pordy) begin
                total++;
                if (qp.size() == 0) begin
                    bad++;
                    $display("FAIL mon_p_unexpected got s=%h required none", ps);
                end else begin
                    pe = qp.pop_front();
                    if (ps !== pe.s || povf[0] !== pe.ovf) begin
                        bad++;
                        $display("FAIL mon_p_result got s=%h ovf=%b required s=%h ovf=%b", ps, povf, pe.s, pe.ovf);
                    end
                end
            end
            if (piv && pir) begin
                m0 = model(16, int'($signed(pa)), int'($signed(pb)), padd[0]);
                pe.s   = m0[15:0];
                pe.ovf = m0[16];
                qp.push_back(pe);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int a0, input int b0, input bit ad0,
                          input int a1, input int b1, input bit ad1);
        a   = {a1[7:0], a0[7:0]};
        b   = {b1[7:0], b0[7:0]};
        add = {ad1, ad0};
        iv  = 1'b1;
    endtask

    // Holds the operand set until a handshake is seen just before a rising edge.
    task automatic send(input int a0, input int b0, input bit ad0,
                        input int a1, input int b1, input bit ad1);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        set_in(a0, b0, ad0, a1, b1, ad1);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ir;
            tick();
            n++;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout got accepted=0 required accepted=1");
        end
        iv = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d required pending=0", qa.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; add = '0;
        piv = 1'b0; pordy = 1'b1; pa = '0; pb = '0; padd = '0;
        #1 rstn = 1'b0;
        #1;
        total++;
        if (ov !== 1'b0 || s !== 16'h0 || ovf !== 2'b00 || ir !== 1'b1) begin
            bad++;
            $display("FAIL reset_init got ov=%b s=%h ovf=%b ir=%b required 0 0000 00 1", ov, s, ovf, ir);
        end
        tick(); tick();
        rstn = 1'b1;
        tick();
        send(1, 2, 1'b1, 3, 4, 1'b1);
        send(7, 7, 1'b0, -8, 9, 1'b1);
        rstn = 1'b0;
        qa.delete();
        #1;
        total++;
        if (ov !== 1'b0 || s !== 16'h0 || ovf !== 2'b00 || ir !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got ov=%b s=%h ovf=%b ir=%b required 0 0000 00 1", ov, s, ovf, ir);
        end
        total++;
        if (pov !== 1'b0 || ps !== 16'h0 || pir !== 1'b1) begin
            bad++;
            $display("FAIL reset_par got ov=%b s=%h ir=%b required 0 0000 1", pov, ps, pir);
        end
        set_in(11, 22, 1'b1, 33, 44, 1'b1);
        tick(); tick();
        iv = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ov !== 1'b0) begin
                bad++;
                $display("FAIL reset_stale cycle=%0d got ov=%b required 0", i, ov);
            end
        end
    endtask

    task automatic test_basic();
        int rx0;
        ordy = 1'b1;
        send(5, 3, 1'b1, -4, 10, 1'b0);
        total++;
        if (ov !== 1'b0) begin
            bad++;
            $display("FAIL basic_early got ov=%b required 0", ov);
        end
        tick();
        total++;
        if (ov !== 1'b1 || s !== 16'hF208 || ovf !== 2'b00) begin
            bad++;
            $display("FAIL basic_first got ov=%b s=%h ovf=%b required 1 f208 00", ov, s, ovf);
        end
        tick();
        rx0 = rx;
        for (int i = 0; i < 6; i++)
            send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'($urandom_range(1)),
                 int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'($urandom_range(1)));
        tick(); tick();
        total++;
        if (rx - rx0 != 6) begin
            bad++;
            $display("FAIL basic_throughput got results=%0d required 6", rx - rx0);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [15:0] es;
`ifdef C_ADDSUB_SAT_EN
        es = 16'h807F;
`else
        es = 16'h6096;
`endif
        ordy = 1'b1;
        send(100, 50, 1'b1, -100, 60, 1'b0);
        tick();
        total++;
        if (ov !== 1'b1 || s !== es || ovf !== 2'b11) begin
            bad++;
            $display("FAIL overflow got ov=%b s=%h ovf=%b required 1 %h 11", ov, s, ovf, es);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int          rx0;
        logic [16:0] m0, m1;
        logic [15:0] es0;
        m0  = model(8, 1, 0, 1'b1);
        m1  = model(8, 0, 3, 1'b0);
        es0 = {m1[7:0], m0[7:0]};
        rx0 = rx;
        ordy = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(10 * i + 1, i, 1'b1, -7 * i, 3, i[0]);
            end
            begin
                int n;
                n = 0;
                while (ov !== 1'b1 && n < 20) begin
                    tick();
                    n++;
                end
                for (int c = 0; c < 4; c++) begin
                    total++;
                    if (ir !== 1'b0 || ov !== 1'b1 || s !== es0) begin
                        bad++;
                        $display("FAIL bp_stall cycle=%0d got ir=%b ov=%b s=%h required 0 1 %h", c, ir, ov, s, es0);
                    end
                    tick();
                end
                #1 ordy = 1'b1;
            end
        join
        drain();
        total++;
        if (rx - rx0 != 5) begin
            bad++;
            $display("FAIL bp_count got results=%0d required 5", rx - rx0);
        end
    endtask

    task automatic test_bubbles();
        logic [4:0] v;
        logic       ev;
        v = 5'b00101;
        ordy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (v[c]) set_in(c, 1, 1'b1, c, 2, 1'b0);
            else iv = 1'b0;
            tick();
            ev = (c == 0) ? 1'b0 : v[c-1];
            total++;
            if (ov !== ev) begin
                bad++;
                $display("FAIL bubble cycle=%0d got ov=%b required %b", c, ov, ev);
            end
        end
        iv = 1'b0;
        drain();
    endtask

    task automatic test_parametric();
        logic [15:0] es;
`ifdef C_ADDSUB_SAT_EN
        es = 16'h8000;
`else
        es = 16'h7FFF;
`endif
        pa = 16'h8000; pb = 16'h0001; padd = 1'b0; piv = 1'b1;
        tick();
        piv = 1'b0;
        total++;
        if (pov !== 1'b1 || povf !== 1'b1 || ps !== es) begin
            bad++;
            $display("FAIL par_result got ov=%b ovf=%b s=%h required 1 1 %h", pov, povf, ps, es);
        end
        tick();
        total++;
        if (pov !== 1'b0) begin
            bad++;
            $display("FAIL par_after got ov=%b required 0", pov);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_bubbles();
        test_parametric();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
